// File: rtl/arb_pkg.sv
// Shared types and mode constants for the round-robin / fixed-priority arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  localparam int unsigned RR    = 0;
  localparam int unsigned FIXED = 1;

endpackage

// File: rtl/rr_pick.sv
// Combinational first-set-bit search over vec, starting at index start and wrapping modulo N.
module rr_pick #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         vec,
  input  logic [$clog2(N)-1:0] start,
  output logic                 found,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] idx
);

  localparam int unsigned IW = $clog2(N);

  int unsigned j;

  always_comb begin
    found  = 1'b0;
    onehot = '0;
    idx    = '0;
    j      = 0;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(start) + i;
      if (j >= N) j = j - N;
      if (!found && vec[j]) begin
        found     = 1'b1;
        onehot[j] = 1'b1;
        idx       = IW'(j);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Single-owner arbiter with round-robin or fixed priority, explicit release,
// request-drop release and an optional hold timeout. All outputs are registered.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned MAX_HOLD   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 rel,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [HW-1:0]   hold_cnt;

  logic [IW-1:0]   start_c;
  logic            found_c;
  logic [N-1:0]    onehot_c;
  logic [IW-1:0]   idx_c;
  logic            timeout_c;
  logic            rel_c;
  logic [IW-1:0]   nxt_ptr_c;

  // ptr always equals owner+1 while OWNED, so the old owner ranks last on release
  assign start_c = (FIXED_PRIO == FIXED) ? '0 : ptr;

  rr_pick #(.N(N)) u_pick (
    .vec    (req),
    .start  (start_c),
    .found  (found_c),
    .onehot (onehot_c),
    .idx    (idx_c)
  );

  generate
    if (MAX_HOLD != 0) begin : g_timeout
      assign timeout_c = (hold_cnt == HW'(MAX_HOLD - 1));
    end else begin : g_no_timeout
      assign timeout_c = 1'b0;
    end
  endgenerate

  assign rel_c     = rel | ~req[grant_id] | timeout_c;
  assign nxt_ptr_c = (32'(idx_c) == N - 1) ? '0 : idx_c + IW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found_c) begin
            state    <= OWNED;
            grant    <= onehot_c;
            grant_id <= idx_c;
            busy     <= 1'b1;
            ptr      <= nxt_ptr_c;
            hold_cnt <= '0;
          end
        end
        OWNED: begin
          if (rel_c && found_c) begin
            grant    <= onehot_c;
            grant_id <= idx_c;
            ptr      <= nxt_ptr_c;
            hold_cnt <= '0;
          end else if (rel_c) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
          end else if (MAX_HOLD != 0) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          grant    <= '0;
          grant_id <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: directed scenarios plus randomized traffic against a behavioural owner model.
module tb_rr_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req;
  logic         rel;

  logic [N-1:0] g_rr, g_fx;
  logic [1:0]   id_rr, id_fx;
  logic         b_rr, b_fx;

  int n_cmp = 0;
  int n_err = 0;

  // model state: owner index (-1 = none), pointer, cycles held; [0]=round-robin, [1]=fixed
  int m_owner [2];
  int m_ptr   [2];
  int m_hold  [2];

  rr_arbiter #(.N(N), .FIXED_PRIO(0), .MAX_HOLD(MH)) dut_rr (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel),
    .grant(g_rr), .grant_id(id_rr), .busy(b_rr)
  );

  rr_arbiter #(.N(N), .FIXED_PRIO(1), .MAX_HOLD(MH)) dut_fx (
    .clk(clk), .rst_n(rst_n), .req(req), .rel(rel),
    .grant(g_fx), .grant_id(id_fx), .busy(b_fx)
  );

  always #5 clk = ~clk;

  function automatic int model_pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_grant(input int m);
    logic [N-1:0] v;
    v = '0;
    if (m_owner[m] >= 0) v[m_owner[m]] = 1'b1;
    return v;
  endfunction

  function automatic logic [1:0] exp_id(input int m);
    return (m_owner[m] >= 0) ? 2'(m_owner[m]) : 2'd0;
  endfunction

  // advance one clock: update both models with the inputs seen at the edge, then settle
  task automatic tick();
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      int start, w;
      bit give_up;
      if (!rst_n) begin
        m_owner[m] = -1; m_ptr[m] = 0; m_hold[m] = 0;
      end else begin
        start = (m == 1) ? 0 : m_ptr[m];
        w = model_pick(req, start);
        if (m_owner[m] < 0) begin
          give_up = 1'b1;
        end else begin
          give_up = rel || !req[m_owner[m]] || (m_hold[m] == MH - 1);
        end
        if (give_up) begin
          m_owner[m] = w;
          m_hold[m]  = 0;
          if (w >= 0) m_ptr[m] = (w + 1) % N;
        end else begin
          m_hold[m]++;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; rel = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; rel = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (g_rr !== 4'b0000 || b_rr !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d grant=%b busy=%b want grant=0000 busy=0", c, g_rr, b_rr);
      end
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (g_rr !== 4'b0001 || b_rr !== 1'b1 || id_rr !== 2'd0) begin
      n_err++;
      $display("FAIL reset_first_grant grant=%b id=%0d busy=%b want 0001/0/1", g_rr, id_rr, b_rr);
    end
  endtask

  task automatic test_rotation();
    logic [N-1:0] seq [5];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    do_reset();
    req = 4'b1111; rel = 1'b0;
    tick();
    rel = 1'b1;
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (g_rr !== seq[c]) begin
        n_err++;
        $display("FAIL rotation step=%0d grant=%b want=%b", c, g_rr, seq[c]);
      end
      tick();
    end
    rel = 1'b0;
  endtask

  task automatic test_fixed();
    do_reset();
    req = 4'b1010; rel = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++;
      if (g_fx !== 4'b0010 || id_fx !== 2'd1) begin
        n_err++;
        $display("FAIL fixed_prio cyc=%0d grant=%b id=%0d want 0010/1", c, g_fx, id_fx);
      end
    end
    rel = 1'b0;
  endtask

  task automatic test_timeout();
    logic [N-1:0] want;
    do_reset();
    req = 4'b0101; rel = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      want = (c < 4 || c >= 8) ? 4'b0001 : 4'b0100;
      n_cmp++;
      if (g_rr !== want) begin
        n_err++;
        $display("FAIL timeout cyc=%0d grant=%b want=%b", c, g_rr, want);
      end
    end
  endtask

  task automatic test_drop_idle();
    do_reset();
    req = 4'b0010; rel = 1'b0;
    tick();
    n_cmp++;
    if (g_rr !== 4'b0010) begin
      n_err++;
      $display("FAIL drop_setup grant=%b want=0010", g_rr);
    end
    req = 4'b0000;
    tick();
    n_cmp++;
    if (g_rr !== 4'b0000 || b_rr !== 1'b0 || id_rr !== 2'd0) begin
      n_err++;
      $display("FAIL drop_idle grant=%b busy=%b id=%0d want 0000/0/0", g_rr, b_rr, id_rr);
    end
    req = 4'b1000;
    tick();
    n_cmp++;
    if (g_rr !== 4'b1000 || id_rr !== 2'd3 || b_rr !== 1'b1) begin
      n_err++;
      $display("FAIL drop_regrant grant=%b id=%0d busy=%b want 1000/3/1", g_rr, id_rr, b_rr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 4'b0100; rel = 1'b0;
    tick();
    n_cmp++;
    if (g_rr !== 4'b0100) begin
      n_err++;
      $display("FAIL midreset_setup grant=%b want=0100", g_rr);
    end
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if (g_rr !== 4'b0000 || b_rr !== 1'b0 || dut_rr.ptr !== 2'd0) begin
      n_err++;
      $display("FAIL midreset_drop grant=%b busy=%b ptr=%0d want 0000/0/0", g_rr, b_rr, dut_rr.ptr);
    end
    rst_n = 1'b1; req = 4'b1111;
    tick();
    n_cmp++;
    if (g_rr !== 4'b0001) begin
      n_err++;
      $display("FAIL midreset_first grant=%b want=0001", g_rr);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req   = 4'($urandom_range(0, 15));
      rel   = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 60) != 0);
      tick();
      n_cmp++;
      if (g_rr !== exp_grant(0) || id_rr !== exp_id(0) || b_rr !== (m_owner[0] >= 0)) begin
        n_err++;
        $display("FAIL random_rr cyc=%0d grant=%b id=%0d busy=%b want %b/%0d/%b",
                 c, g_rr, id_rr, b_rr, exp_grant(0), exp_id(0), m_owner[0] >= 0);
      end
      n_cmp++;
      if (g_fx !== exp_grant(1) || id_fx !== exp_id(1) || b_fx !== (m_owner[1] >= 0)) begin
        n_err++;
        $display("FAIL random_fx cyc=%0d grant=%b id=%0d busy=%b want %b/%0d/%b",
                 c, g_fx, id_fx, b_fx, exp_grant(1), exp_id(1), m_owner[1] >= 0);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; rel = 1'b0;
    for (int m = 0; m < 2; m++) begin
      m_owner[m] = -1; m_ptr[m] = 0; m_hold[m] = 0;
    end
    test_reset();
    test_rotation();
    test_fixed();
    test_timeout();
    test_drop_idle();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 Parameter N, default 8: number of requesters; legal range 2..32.
REQ-002 Parameter FIXED_PRIO, default 0: 0 selects round-robin, 1 selects fixed priority (bit 0 highest).
REQ-003 Parameter MAX_HOLD, default 16: maximum cycles one owner holds a grant; 0 disables the timeout.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset; synchronous and active-low.
REQ-006 req  input  N  per-requester request level; bit i = requester i.
REQ-007 release  input  1  current owner gives up the grant this cycle.
REQ-008 grant  output  N  registered one-hot grant, or all-zero.
REQ-009 grant_id  output  $clog2(N)  binary index of the set grant bit; 0 when grant is 0.
REQ-010 busy  output  1  high while any grant is asserted.

Function
REQ-011 The FSM SHALL have two states: IDLE (no owner) and OWNED (exactly one grant bit set).
REQ-012 Winner selection SHALL be the first set bit of the candidate vector.
REQ-013 In round-robin mode, the scan SHALL start at pointer ptr and wrap modulo N.
REQ-014 In fixed mode, the scan SHALL start at bit 0 and ptr SHALL be ignored.
REQ-015 In IDLE with req != 0, the next edge SHALL enter OWNED with grant set to the winner; request-to-grant latency is 1 cycle.
REQ-016 In IDLE with req == 0, the FSM SHALL stay in IDLE; release SHALL be ignored.
REQ-017 In OWNED, the owner SHALL be released at the edge following any of the following conditions:
- release = 1;
- req[owner] = 0;
- timeout: MAX_HOLD != 0 and hold_cnt == MAX_HOLD-1.
REQ-018 On a release edge with req != 0, the FSM SHALL remain in OWNED and grant the new winner at that same edge, with no idle cycle.
REQ-019 On a release edge, the new winner SHALL be computed with ptr already set to owner+1 mod N, so the previous owner has lowest priority in round-robin mode.
REQ-020 On a release edge with req == 0, the FSM SHALL go to IDLE and grant SHALL become 0.
REQ-021 On a timeout with only the owner still requesting, the owner SHALL be re-granted and hold_cnt SHALL restart at 0.
REQ-022 On each new grant, ptr SHALL become (winner+1) mod N, wrapping from N-1 to 0.
REQ-023 hold_cnt SHALL clear to 0 on each new grant and increment once per OWNED cycle.
REQ-024 hold_cnt width SHALL be $clog2(MAX_HOLD+1), and it SHALL never exceed MAX_HOLD-1.
REQ-025 Without a release condition, the grant SHALL stay stable; changes on other req bits SHALL have no effect on it.
REQ-026 grant SHALL never have more than one bit set.
REQ-027 grant, grant_id and busy SHALL all be driven directly from registers.

Reset
REQ-028 While rst_n = 0 at an edge, the block SHALL set:
- state = IDLE;
- grant = 0, grant_id = 0, busy = 0;
- ptr = 0, hold_cnt = 0.
REQ-029 Reset asserted while OWNED SHALL drop grant at that edge, with no release handshake.
REQ-030 After rst_n rises, the first grant SHALL follow the IDLE rule.

Structure
REQ-031 Shared package arb_pkg SHALL hold the state enum (IDLE, OWNED) and the mode constants RR = 0 and FIXED = 1.
REQ-032 Sub-module rr_pick SHALL contain the combinational selection logic:
- parameter N;
- inputs vec[N-1:0] and start[$clog2(N)-1:0];
- outputs found, onehot[N-1:0] and idx.
REQ-033 Only rr_arbiter SHALL contain state.

Verification (N = 4, MAX_HOLD = 4 unless noted)
REQ-034 Reset/idle: hold rst_n = 0 for 2 cycles with req = 4'b1111.
- Required: grant = 0 and busy = 0 throughout reset.
- Required: grant = 4'b0001 one cycle after rst_n rises.
REQ-035 Round-robin rotation: req = 4'b1111 held, release pulsed every cycle.
- Required: grant sequence 0001, 0010, 0100, 1000, 0001 (wrap).
REQ-036 Fixed priority (FIXED_PRIO = 1): req = 4'b1010, release every cycle.
- Required: grant stays 0010 on every cycle.
REQ-037 Timeout: req = 4'b0101 held, release = 0.
- Required: 0001 held exactly 4 cycles, then 0100 for 4 cycles, then 0001.
REQ-038 Drop and idle: owner 0010; req goes 4'b0010 -> 0.
- Required: next edge grant = 0, busy = 0, grant_id = 0.
- Then req = 4'b1000: grant = 1000 one cycle later, grant_id = 3.
REQ-039 Reset mid-grant: rst_n = 0 while grant = 0100.
- Required: grant = 0 at that edge, and ptr = 0 afterwards.
- Check: the first grant after reset with req = 4'b1111 is 0001.
